// File: rtl/hs_rx_fifo_if.sv
// Word handshake bundle between the transmitter, this receiver and the
// downstream consumer. The receiver uses the slave view: it sinks s_* words
// and sources m_* words.
interface hs_rx_fifo_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready,
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport master (
        output s_data,
        output s_valid,
        input  s_ready,
        input  m_data,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/hs_rx_fifo.sv
// Receiver for the valid/ready word handshake: small first-word-fall-through
// FIFO, accepted-word counter and a sticky checker that flags a transmitter
// withdrawing or changing a word it offered while stalled.
module hs_rx_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    hs_rx_fifo_if.slave        bus,
    output logic [ADDR_W:0]    count,
    output logic [CNT_W-1:0]   rx_cnt,
    output logic               proto_err,
    input  logic               err_clr
);
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic              proto_err_q, proto_err_d;
    logic              init_done_q;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] pend_data_q;

    logic s_ready_w;
    logic m_valid_w;
    logic push;
    logic pop;
    logic violation;

    // Handshake outputs decoded from registered state only, so s_ready has
    // no combinational dependence on s_valid or m_ready.
    always_comb begin
        s_ready_w   = init_done_q & (count_q != FULL);
        m_valid_w   = (count_q != '0);
        bus.s_ready = s_ready_w;
        bus.m_valid = m_valid_w;
        bus.m_data  = m_valid_w ? mem[rd_ptr_q] : '0;
        count       = count_q;
        rx_cnt      = rx_cnt_q;
        proto_err   = proto_err_q;
    end

    // Next-state for pointers, occupancy, counter and checker.
    always_comb begin
        push      = bus.s_valid & s_ready_w;
        pop       = m_valid_w & bus.m_ready;
        violation = pend_q & (~bus.s_valid | (bus.s_data != pend_data_q));

        wr_ptr_d  = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        rx_cnt_d  = push ? rx_cnt_q + CNT_W'(1)  : rx_cnt_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase

        // A new violation beats a clear arriving on the same edge.
        if (violation)    proto_err_d = 1'b1;
        else if (err_clr) proto_err_d = 1'b0;
        else              proto_err_d = proto_err_q;

        pend_d = bus.s_valid & ~s_ready_w;
    end

    // Control state; reset discards everything buffered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rx_cnt_q    <= '0;
            proto_err_q <= 1'b0;
            init_done_q <= 1'b0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rx_cnt_q    <= rx_cnt_d;
            proto_err_q <= proto_err_d;
            init_done_q <= 1'b1;
            pend_q      <= pend_d;
            pend_data_q <= bus.s_data;
        end
    end

    // Word storage is left unreset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.s_data;
    end
endmodule
